// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter in front of a private bank of JK
// registers. One requester's per-bit JK command is committed every 2 cycles.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   req[NREQ]       request levels, held until ack
//   addr/j/k        per-requester address and JK vectors (sliced by index)
//   gnt/ack         registered one-hot grant (APPLY) and completion pulse
//   err             pulses with ack when address >= DEPTH
//   busy            high during APPLY
//   q/qbar          bank contents and their complement
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*AW-1:0]     addr,
  input  logic [NREQ*WIDTH-1:0]  j,
  input  logic [NREQ*WIDTH-1:0]  k,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic                   err,
  output logic                   busy,
  output logic [DEPTH*WIDTH-1:0] q,
  output logic [DEPTH*WIDTH-1:0] qbar
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    S_IDLE,
    S_APPLY
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_sel;
  logic [AW-1:0]     r_addr;
  logic [WIDTH-1:0]  r_j;
  logic [WIDTH-1:0]  r_k;
  logic [WIDTH-1:0]  r_bank [DEPTH];
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_ack;
  logic              r_err;
  logic              r_busy;

  logic [NREQ-1:0]   w_elig;
  logic              w_any;
  logic [PW-1:0]     w_pick;
  logic              w_oor;
  logic [PW-1:0]     w_ptr_nxt;

  // Masking with ack stops the just-served requester being regranted
  // while its req is still high in the ack cycle.
  assign w_elig = req & ~r_ack;

  // Scan from the pointer upward with wrap; iterating from the far end
  // lets the lowest offset win by being assigned last.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      if (w_elig[(int'(r_ptr) + o) % NREQ]) begin
        w_any  = 1'b1;
        w_pick = PW'((int'(r_ptr) + o) % NREQ);
      end
    end
  end

  assign w_oor     = 32'(r_addr) >= 32'(DEPTH);
  assign w_ptr_nxt = (r_sel == PW'(NREQ - 1)) ? '0 : r_sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        r_bank[r] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= '0;
          r_err <= 1'b0;
          if (w_any) begin
            r_gnt   <= NREQ'(1) << w_pick;
            r_sel   <= w_pick;
            r_addr  <= addr[w_pick*AW +: AW];
            r_j     <= j[w_pick*WIDTH +: WIDTH];
            r_k     <= k[w_pick*WIDTH +: WIDTH];
            r_busy  <= 1'b1;
            r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          // An out-of-range address matches no register.
          for (int r = 0; r < DEPTH; r++) begin
            if (r_addr == AW'(r)) begin
              r_bank[r] <= (r_j & ~r_bank[r]) |
                           (~r_k & r_bank[r]);
            end
          end
          r_ack   <= r_gnt;
          r_err   <= w_oor;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= w_ptr_nxt;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_q
    assign q[g*WIDTH +: WIDTH] = r_bank[g];
  end

  assign qbar = ~q;
  assign gnt  = r_gnt;
  assign ack  = r_ack;
  assign err  = r_err;
  assign busy = r_busy;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed bench for jk_bank_arbiter
// (NREQ=4, DEPTH=3, WIDTH=8, AW=2).
module tb_jk_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int DEPTH = 3;
  localparam int WIDTH = 8;
  localparam int AW    = 2;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*AW-1:0]     addr;
  logic [NREQ*WIDTH-1:0]  j;
  logic [NREQ*WIDTH-1:0]  k;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic                   err;
  logic                   busy;
  logic [DEPTH*WIDTH-1:0] q;
  logic [DEPTH*WIDTH-1:0] qbar;

  int n_tests = 0;
  int n_fail  = 0;

  jk_bank_arbiter #(
    .NREQ (NREQ),
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .addr (addr),
    .j    (j),
    .k    (k),
    .gnt  (gnt),
    .ack  (ack),
    .err  (err),
    .busy (busy),
    .q    (q),
    .qbar (qbar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_q(string tag, logic [23:0] qexp);
    logic [23:0] qb;
    qb = ~qexp;
    chk({tag, ".q"}, 32'(q), 32'(qexp));
    chk({tag, ".qbar"}, 32'(qbar), 32'(qb));
  endtask

  // One full command: grant, commit/ack, ack drop.
  task automatic issue(string tag, int i, logic [1:0] a,
                       logic [7:0] jv, logic [7:0] kv,
                       logic [23:0] qexp, logic eexp);
    logic [3:0] oh;
    oh = 4'(1 << i);
    @(negedge clk);
    req[i]          = 1'b1;
    addr[i*AW +: AW] = a;
    j[i*WIDTH +: WIDTH] = jv;
    k[i*WIDTH +: WIDTH] = kv;
    @(negedge clk);
    chk({tag, ".gnt"}, 32'(gnt), 32'(oh));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".ack0"}, 32'(ack), 32'd0);
    @(negedge clk);
    chk({tag, ".ack"}, 32'(ack), 32'(oh));
    chk({tag, ".gnt_off"}, 32'(gnt), 32'd0);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'(eexp));
    chk_q(tag, qexp);
    req[i] = 1'b0;
    @(negedge clk);
    chk({tag, ".ack_off"}, 32'(ack), 32'd0);
    chk({tag, ".err_off"}, 32'(err), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int order [5];
    order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    req   = '0;
    addr  = '0;
    j     = '0;
    k     = '0;
    #1;
    chk_q("rst", 24'h000000);
    chk("rst.gnt", 32'(gnt), 32'd0);
    chk("rst.ack", 32'(ack), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue("set2", 0, 2'd2, 8'hF0, 8'h00, 24'hF00000, 1'b0);
    issue("ld1", 1, 2'd1, 8'hA5, 8'h5A, 24'hF0A500, 1'b0);
    issue("tog1", 2, 2'd1, 8'hFF, 8'hFF, 24'hF05A00, 1'b0);
    issue("clr1", 3, 2'd1, 8'h00, 8'h0F, 24'hF05000, 1'b0);
    issue("hold1", 0, 2'd1, 8'h00, 8'h00, 24'hF05000, 1'b0);

    // Pointer is 1: serve 2 alone, then 0 and 2 together.
    issue("rr2", 2, 2'd0, 8'h00, 8'h00, 24'hF05000, 1'b0);
    @(negedge clk);
    addr = '0;
    j    = '0;
    k    = '0;
    req  = 4'b0101;
    @(negedge clk);
    chk("fair.gnt_a", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("fair.ack_a", 32'(ack), 32'h1);
    req[0] = 1'b0;
    @(negedge clk);
    chk("fair.gnt_b", 32'(gnt), 32'h4);
    chk("fair.ack_b0", 32'(ack), 32'h0);
    @(negedge clk);
    chk("fair.ack_b", 32'(ack), 32'h4);
    req[2] = 1'b0;

    issue("oor", 3, 2'd3, 8'hFF, 8'h00, 24'hF05000, 1'b1);

    // Reset while the set on reg0 is in APPLY.
    @(negedge clk);
    req[0]    = 1'b1;
    addr[1:0] = 2'd0;
    j[7:0]    = 8'hFF;
    k[7:0]    = 8'h00;
    @(negedge clk);
    chk("mid.gnt", 32'(gnt), 32'h1);
    rst_n = 1'b0;
    #1;
    chk_q("mid", 24'h000000);
    chk("mid.gnt_rst", 32'(gnt), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    req[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid.noack", 32'(ack), 32'd0);
    end
    chk_q("mid.hold", 24'h000000);
    rst_n = 1'b1;
    issue("fresh", 0, 2'd0, 8'h3C, 8'h00, 24'h00003C, 1'b0);

    // All four keep requesting: expect 0,1,2,3,0 every 2 cycles.
    pulse_reset();
    @(negedge clk);
    j   = '0;
    k   = '0;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk($sformatf("cont%0d.gnt", n), 32'(gnt), 32'(1 << order[n]));
      chk($sformatf("cont%0d.ack0", n), 32'(ack), 32'd0);
      @(negedge clk);
      chk($sformatf("cont%0d.ack", n), 32'(ack), 32'(1 << order[n]));
      chk($sformatf("cont%0d.gnt0", n), 32'(gnt), 32'd0);
    end
    req = '0;
    @(negedge clk);
    chk("cont.idle_gnt", 32'(gnt), 32'd0);
    chk_q("cont", 24'h000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_arbiter.md
Name: jk_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared bank of JK storage registers.
- Up to NREQ requesters each issue a per-bit JK command (hold/clear/set/toggle) against one addressed register.
- The block grants one requester at a time, commits the command to the bank on a clock edge, and acknowledges completion.
- It sits between control FSMs that need shared flag/status bits and the JK register bank. The bank is internal to this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DEPTH, 4, number of JK registers in the bank (1..16).
- WIDTH, 8, bits per register.
- AW, 2, address width; must satisfy 2**AW >= DEPTH.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester request level; held high until the matching ack.
- addr  input  NREQ*AW  per-requester register address; slice i = bits [i*AW +: AW].
- j  input  NREQ*WIDTH  per-requester J vector; slice i = [i*WIDTH +: WIDTH].
- k  input  NREQ*WIDTH  per-requester K vector, same slicing as j.
- gnt  output  NREQ  registered one-hot grant, high only during the APPLY cycle.
- ack  output  NREQ  registered one-hot completion pulse, exactly 1 cycle.
- err  output  1  pulses with ack when the committed address was >= DEPTH.
- busy  output  1  high while in APPLY.
- q  output  DEPTH*WIDTH  bank contents; register r = [r*WIDTH +: WIDTH].
- qbar  output  DEPTH*WIDTH  bitwise complement of q at all times.

Behaviour:
- Reset (async, rst_n=0):
  - q = 0; qbar = all ones.
  - gnt, ack, err, busy = 0.
  - state = IDLE; round-robin pointer = 0, so requester 0 has highest priority.
  - Reset asserted during APPLY abandons the command: no bank write, no ack.
- Per-bit JK command, committed as one edge: j=0,k=0 hold; j=0,k=1 clear; j=1,k=0 set; j=1,k=1 toggle (uses the pre-edge value).
- FSM states IDLE and APPLY:
  - IDLE: eligible = req & ~ack. If eligible is non-zero, pick the first eligible index scanning from the pointer upward, with wrap-around. Then register gnt[i]=1, latch addr/j/k of requester i, set busy=1 and go to APPLY. If eligible is zero, stay in IDLE.
  - APPLY (always exactly 1 cycle): on the next edge, update register addr_latched with the latched j/k. Set ack[i]=1, and set err=1 if the address is out of range. Clear gnt and busy, set pointer = (i+1) mod NREQ, and return to IDLE.
  - Out-of-range address: no bank bit changes, but ack still pulses.
- Latency:
  - req sampled high at edge n -> gnt high after edge n.
  - q updated and ack high after edge n+1.
  - ack low after edge n+2.
- Throughput: at most one command every 2 cycles.
- Handshake:
  - The requester holds req/addr/j/k stable from req assertion until it sees ack. It must drop req in the cycle following ack, or keep it high to request again.
  - The ack mask prevents double grant during the ack cycle.
  - Latched command values are used; input changes during APPLY have no effect.
- Simultaneous requests resolve only via round-robin. A requester dropping req before grant is never granted and gets no ack.
- No two gnt or ack bits are ever high together.
- qbar is combinational ~q and never differs from it.

Test Plan:
- Single set: after reset, req[0]=1, addr=2, j=8'hF0, k=0 -> gnt=4'b0001 for 1 cycle; next cycle q reg2=8'hF0, ack=4'b0001 for 1 cycle; qbar reg2=8'h0F.
- Toggle/clear/hold on reg1 starting at 8'hA5:
  - j=k=8'hFF -> 8'h5A.
  - Then j=0,k=8'h0F -> 8'h50.
  - Then j=k=0 -> 8'h50 unchanged, ack still pulses.
- Contention: req=4'b1111 held, with each requester re-requesting after its ack -> grant order 0,1,2,3,0. Grants arrive every 2 cycles, never overlapping, and ack is one-hot each time.
- Round-robin fairness: grant requester 2, then req=4'b0101 -> requester 0 is granted before requester 2 is granted again.
- Out of range (DEPTH=3, AW=2): addr=3, j=8'hFF -> ack and err pulse together; all q unchanged.
- Reset mid-operation: assert rst_n=0 during APPLY of a set on reg0 -> q all 0, gnt/ack/busy 0, no ack ever seen. After release, a fresh req from requester 0 completes normally in 2 cycles.
